// File: rtl/dl11_fifo_regs.sv
// DL11 serial line register file with RX/TX byte FIFOs and two-source interrupt logic.
// Define DL11_RX_ERR_EN to report receive overruns in RBUF bits 15 (ERR) and 14 (OVR).
module dl11_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_dout  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wp[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
            if (i_pop)  r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
        end
    end
endmodule

module dl11_fifo_regs #(
    parameter logic [12:0] BASE_ADDR = 13'o17560,
    parameter logic [7:0]  VECTOR    = 8'o60,
    parameter int          RX_DEPTH  = 4,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    output logic [15:0] data_out,
    output logic        decode,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [7:0]  vector,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_byte,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    logic [12:0] w_off;
    logic [1:0]  w_sel;
    logic        w_odd, w_rd, w_wr, w_lo_wr;
    logic [15:0] w_word, w_rbuf;
    logic [7:0]  w_rx_head;
    logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic        w_rx_pop, w_rx_push, w_rx_drop, w_tx_push, w_tx_pop;
    logic        w_ready, w_rx_req, w_tx_req, w_flag_set;
    logic [1:0]  w_err;
    logic        r_rie, r_tie, r_tflag, r_ready_q;

    assign w_off   = iopage_addr - BASE_ADDR;
    assign decode  = (w_off[12:3] == '0);
    assign w_sel   = w_off[2:1];
    assign w_odd   = iopage_byte_op & w_off[0];
    assign w_rd    = iopage_rd & decode;
    assign w_wr    = iopage_wr & decode;
    // Odd byte writes carry only the high lane, where no writable bit lives.
    assign w_lo_wr = w_wr & ~w_odd;

    assign w_rx_pop  = w_rd && (w_sel == 2'd1) && !w_odd && !w_rx_empty;
    assign w_rx_push = rx_strobe && (!w_rx_full || w_rx_pop);
    assign w_rx_drop = rx_strobe && w_rx_full && !w_rx_pop;
    assign w_tx_push = w_lo_wr && (w_sel == 2'd3) && !w_tx_full;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_ready   = ~w_tx_full;
    assign tx_valid  = ~w_tx_empty;

    dl11_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .reset(reset), .i_push(w_rx_push), .i_din(rx_byte),
        .i_pop(w_rx_pop), .o_dout(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    dl11_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .reset(reset), .i_push(w_tx_push), .i_din(data_in[7:0]),
        .i_pop(w_tx_pop), .o_dout(tx_data), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

`ifdef DL11_RX_ERR_EN
    logic r_ovr;
    always_ff @(posedge clk) begin
        if (reset)          r_ovr <= 1'b0;
        else if (w_rx_drop) r_ovr <= 1'b1;
        else if (w_rx_pop)  r_ovr <= 1'b0;
    end
    assign w_err = {r_ovr, r_ovr};
`else
    assign w_err = 2'b00;
`endif

    assign w_rbuf = w_rx_empty ? '0 : {w_err, 6'b0, w_rx_head};

    always_comb begin
        w_word = '0;
        case (w_sel)
            2'd0:    w_word = {8'b0, ~w_rx_empty, r_rie, 6'b0};
            2'd1:    w_word = w_rbuf;
            2'd2:    w_word = {8'b0, w_ready, r_tie, 6'b0};
            default: w_word = '0;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (w_rd) begin
            if (!iopage_byte_op) data_out = w_word;
            else if (w_odd)      data_out = {8'b0, w_word[15:8]};
            else                 data_out = {8'b0, w_word[7:0]};
        end
    end

    assign w_rx_req   = r_rie & ~w_rx_empty;
    assign w_tx_req   = r_tie & r_tflag;
    assign interrupt  = w_rx_req | w_tx_req;
    assign vector     = w_rx_req ? VECTOR : (w_tx_req ? VECTOR + 8'd4 : 8'd0);
    assign w_flag_set = (w_ready && !r_ready_q) ||
                        (w_lo_wr && (w_sel == 2'd2) && data_in[6] && w_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rie     <= 1'b0;
            r_tie     <= 1'b0;
            r_tflag   <= 1'b1;
            r_ready_q <= 1'b1;
        end else begin
            r_ready_q <= w_ready;
            if (w_lo_wr && (w_sel == 2'd0)) r_rie <= data_in[6];
            if (w_lo_wr && (w_sel == 2'd2)) r_tie <= data_in[6];
            if (w_flag_set)
                r_tflag <= 1'b1;
            else if (interrupt_ack && w_tx_req && !w_rx_req)
                r_tflag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dl11_fifo_regs.sv
// Directed bench for dl11_fifo_regs (default build, default parameters).
module tb_dl11_fifo_regs;
    localparam logic [12:0] RCSR = 13'o17560;
    localparam logic [12:0] RBUF = 13'o17562;
    localparam logic [12:0] XCSR = 13'o17564;
    localparam logic [12:0] XBUF = 13'o17566;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] iopage_addr = '0;
    logic [15:0] data_in = '0;
    logic        iopage_rd = 1'b0, iopage_wr = 1'b0, iopage_byte_op = 1'b0;
    logic [15:0] data_out;
    logic        decode, interrupt, interrupt_ack = 1'b0;
    logic [7:0]  vector;
    logic        rx_strobe = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] d;

    dl11_fifo_regs dut (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .data_out(data_out), .decode(decode), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .vector(vector), .rx_strobe(rx_strobe),
        .rx_byte(rx_byte), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, input logic bo, output logic [15:0] q);
        @(negedge clk); iopage_addr = a; iopage_byte_op = bo; iopage_rd = 1'b1;
        #1 q = data_out;
        @(negedge clk); iopage_rd = 1'b0; iopage_byte_op = 1'b0;
    endtask

    task automatic wr(input logic [12:0] a, input logic bo, input logic [15:0] v);
        @(negedge clk); iopage_addr = a; iopage_byte_op = bo; data_in = v; iopage_wr = 1'b1;
        @(negedge clk); iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk); rx_strobe = 1'b1; rx_byte = b;
        @(negedge clk); rx_strobe = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk); interrupt_ack = 1'b1;
        @(negedge clk); interrupt_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_txvalid", {15'b0, tx_valid}, 16'd0);
        chk("rst_irq", {15'b0, interrupt}, 16'd0);
        chk("rst_vec", {8'b0, vector}, 16'd0);
        rd(XCSR, 1'b0, d); chk("rst_xcsr", d, 16'o000200);
        rd(RCSR, 1'b0, d); chk("rst_rcsr", d, 16'o000000);
        iopage_addr = RCSR; #1 chk("dec_base", {15'b0, decode}, 16'd1);
        iopage_addr = RCSR + 13'd7; #1 chk("dec_top", {15'b0, decode}, 16'd1);
        iopage_addr = RCSR + 13'd8; #1 chk("dec_above", {15'b0, decode}, 16'd0);
        iopage_addr = RCSR - 13'd1; #1 chk("dec_below", {15'b0, decode}, 16'd0);
        iopage_rd = 1'b1; #1 chk("nodec_dout", data_out, 16'd0); iopage_rd = 1'b0;

        // Single receive with interrupt
        strobe(8'h41);
        rd(RCSR, 1'b0, d); chk("rx_done", d, 16'o000200);
        wr(RCSR, 1'b0, 16'o100);
        chk("rx_irq", {15'b0, interrupt}, 16'd1);
        chk("rx_vec", {8'b0, vector}, 16'o60);
        rd(RCSR, 1'b0, d); chk("rx_rcsr_rie", d, 16'o000300);
        rd(RBUF, 1'b0, d); chk("rx_rbuf", d, 16'h0041);
        rd(RCSR, 1'b0, d); chk("rx_done_clr", d, 16'o000100);
        chk("rx_irq_clr", {15'b0, interrupt}, 16'd0);
        chk("rx_vec_clr", {8'b0, vector}, 16'd0);
        wr(RCSR, 1'b0, 16'o0);

        // Overrun: fifth byte dropped; odd byte read does not pop
        for (int unsigned i = 1; i <= 5; i++) strobe(8'(i));
        rd(RBUF + 13'd1, 1'b1, d); chk("rbuf_hi", d, 16'h0000);
        for (int unsigned i = 1; i <= 4; i++) begin
            rd(RBUF, 1'b0, d); chk($sformatf("ovr_rd%0d", i), d, 16'(i));
        end
        rd(RBUF, 1'b0, d); chk("ovr_empty", d, 16'h0000);

        // Pop and push on full FIFO in the same cycle
        for (int unsigned i = 0; i < 4; i++) strobe(8'h11 + 8'(i));
        @(negedge clk); iopage_addr = RBUF; iopage_rd = 1'b1; rx_strobe = 1'b1; rx_byte = 8'h15;
        #1 d = data_out;
        @(negedge clk); iopage_rd = 1'b0; rx_strobe = 1'b0;
        chk("pp_head", d, 16'h0011);
        for (int unsigned i = 0; i < 4; i++) begin
            rd(RBUF, 1'b0, d); chk($sformatf("pp_rd%0d", i), d, 16'h0012 + 16'(i));
        end
        rd(RBUF, 1'b0, d); chk("pp_empty", d, 16'h0000);

        // Transmit FIFO fill, drop, and drain
        tx_ready = 1'b0;
        wr(XBUF, 1'b0, 16'hFF01);
        chk("tx_valid1", {15'b0, tx_valid}, 16'd1);
        chk("tx_data1", {8'b0, tx_data}, 16'h0001);
        for (int unsigned i = 2; i <= 4; i++) wr(XBUF, 1'b0, 16'(i));
        rd(XCSR, 1'b0, d); chk("tx_notready", d, 16'o000000);
        wr(XBUF, 1'b0, 16'h0005);
        chk("tx_stable", {8'b0, tx_data}, 16'h0001);
        @(negedge clk); tx_ready = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) begin
            #1 chk($sformatf("tx_seq%0d", i), {7'b0, tx_valid, tx_data}, {7'b0, 1'b1, 8'(i)});
            @(negedge clk);
        end
        chk("tx_drained", {15'b0, tx_valid}, 16'd0);
        tx_ready = 1'b0;
        wr(XBUF + 13'd1, 1'b1, 16'h7700);
        chk("tx_oddbyte_nopush", {15'b0, tx_valid}, 16'd0);
        wr(XBUF, 1'b1, 16'hAB5A);
        chk("tx_evenbyte", {7'b0, tx_valid, tx_data}, 16'h015A);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        chk("tx_evenbyte_gone", {15'b0, tx_valid}, 16'd0);

        // Transmit interrupt, acknowledge, re-arm by fill/drain
        wr(XCSR, 1'b0, 16'o100);
        chk("ti_vec", {7'b0, interrupt, vector}, {7'b0, 1'b1, 8'o64});
        ack();
        chk("ti_ack", {7'b0, interrupt, vector}, 16'd0);
        for (int unsigned i = 0; i < 4; i++) wr(XBUF, 1'b0, 16'h0030 + 16'(i));
        chk("ti_full_noirq", {15'b0, interrupt}, 16'd0);
        @(negedge clk); tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        tx_ready = 1'b0;
        chk("ti_rearm", {7'b0, interrupt, vector}, {7'b0, 1'b1, 8'o64});

        // Receive has priority; ack while receive selected keeps transmit flag
        wr(RCSR, 1'b0, 16'o100);
        strobe(8'h77);
        chk("pri_rx", {8'b0, vector}, 16'o60);
        ack();
        rd(RBUF, 1'b0, d); chk("pri_rbuf", d, 16'h0077);
        chk("pri_tx_kept", {7'b0, interrupt, vector}, {7'b0, 1'b1, 8'o64});
        ack();
        chk("pri_tx_ack", {15'b0, interrupt}, 16'd0);

        // Reset during transmit discards queued bytes
        wr(XBUF, 1'b0, 16'h00A1);
        wr(XBUF, 1'b0, 16'h00A2);
        strobe(8'h55);
        do_reset();
        chk("rst2_txvalid", {15'b0, tx_valid}, 16'd0);
        chk("rst2_irq", {7'b0, interrupt, vector}, 16'd0);
        rd(XCSR, 1'b0, d); chk("rst2_xcsr", d, 16'o000200);
        rd(RCSR, 1'b0, d); chk("rst2_rcsr", d, 16'o000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
